// File: rtl/ugen_dual_rng.sv
// ugen_dual_rng: binary-to-unary stream source for the stochastic sqrt kernel.
// Converts a latched BW-bit operand into exactly 2^BW unary bits using a
// full-period (zero-inclusive) LFSR, and provides a second independent random
// number per valid cycle for the kernel's output comparator.
// Optional feature macro: UGEN_HOLD_EN adds a 'hold' input that stalls RUN.
module ugen_dual_rng #(
  parameter int unsigned BW     = 6,
  parameter int unsigned SEED_A = 1,
  parameter int unsigned SEED_B = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [BW-1:0] srcVal,
`ifdef UGEN_HOLD_EN
  input  logic          hold,
`endif
  output logic          busy,
  output logic          done,
  output logic          valid,
  output logic          bitOut,
  output logic [BW-1:0] randNum
);

  localparam int unsigned CW = BW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << BW) - 1);
  // Feedback tap masks (bit n-1 corresponds to x^n of the polynomial)
  localparam logic [BW-1:0] TAPS = BW'((BW == 3) ? 8'h06 :
                                       (BW == 4) ? 8'h0C :
                                       (BW == 5) ? 8'h14 :
                                       (BW == 6) ? 8'h30 :
                                       (BW == 7) ? 8'h60 : 8'hB8);
  localparam logic [BW-1:0] SEED_A_V = BW'(SEED_A);
  localparam logic [BW-1:0] SEED_B_V = BW'(SEED_B);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // de Bruijn step: the NOR term splices the all-zero state into the cycle
  function automatic logic [BW-1:0] lfsr_next(input logic [BW-1:0] r);
    logic fb;
    fb = (^(r & TAPS)) ^ ~(|r[BW-2:0]);
    return {r[BW-2:0], fb};
  endfunction

  function automatic logic [BW-1:0] bit_rev(input logic [BW-1:0] v);
    logic [BW-1:0] o;
    for (int i = 0; i < BW; i++) begin
      o[i] = v[BW-1-i];
    end
    return o;
  endfunction

  state_e        state_q, state_d;
  logic [BW-1:0] src_q, src_d;
  logic [BW-1:0] rnga_q, rnga_d;
  logic [BW-1:0] rngb_q, rngb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic          bit_q, bit_d;
  logic [BW-1:0] rand_q, rand_d;
  logic          stall_c;

`ifdef UGEN_HOLD_EN
  assign stall_c = hold;
`else
  assign stall_c = 1'b0;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rnga_d  = rnga_q;
    rngb_d  = rngb_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    valid_d = 1'b0;
    bit_d   = bit_q;
    rand_d  = rand_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = srcVal;
          rnga_d  = SEED_A_V;
          rngb_d  = SEED_B_V;
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        if (!stall_c) begin
          bit_d   = (src_q > rnga_q);
          rand_d  = bit_rev(rngb_q);
          valid_d = 1'b1;
          rnga_d  = lfsr_next(rnga_q);
          rngb_d  = lfsr_next(rngb_q);
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any stream in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      rnga_q  <= SEED_A_V;
      rngb_q  <= SEED_B_V;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rnga_q  <= rnga_d;
      rngb_q  <= rngb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
      rand_q  <= rand_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign valid   = valid_q;
  assign bitOut  = bit_q;
  assign randNum = rand_q;

endmodule

// File: tb/tb_ugen_dual_rng.sv
// Scoreboard bench for ugen_dual_rng (BW=6). Stimulus pushes the expected
// stream (per-bit values from an independent LFSR model, then a done token);
// the monitor pops on every valid/done cycle and checks stream statistics.
`timescale 1ns/1ps
module tb_ugen_dual_rng;

  localparam int unsigned BW = 6;

  typedef struct packed {
    logic          is_done;
    logic          bitv;
    logic [BW-1:0] rn;
    logic [BW-1:0] src;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] srcVal = '0;
`ifdef UGEN_HOLD_EN
  logic          hold = 1'b0;
`endif
  logic          busy, done, valid, bitOut;
  logic [BW-1:0] randNum;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  ugen_dual_rng #(.BW(BW), .SEED_A(1), .SEED_B(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .srcVal(srcVal),
`ifdef UGEN_HOLD_EN
    .hold(hold),
`endif
    .busy(busy), .done(done), .valid(valid), .bitOut(bitOut), .randNum(randNum)
  );

  // Reference x^6+x^5+1 LFSR with the all-zero state spliced in after 100000
  function automatic logic [5:0] model_step(input logic [5:0] r);
    logic fb;
    fb = r[5] ^ r[4];
    if (r[4:0] == 5'd0) fb = ~fb;
    return {r[4:0], fb};
  endfunction

  function automatic logic [5:0] rev6(input logic [5:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction

  task automatic push_stream(input logic [5:0] src);
    logic [5:0] a, b;
    exp_t e;
    a = 6'd1;
    b = 6'd5;
    for (int i = 0; i < 64; i++) begin
      e.is_done = 1'b0; e.bitv = (src > a); e.rn = rev6(b); e.src = src;
      q.push_back(e);
      a = model_step(a);
      b = model_step(b);
    end
    e.is_done = 1'b1; e.bitv = 1'b0; e.rn = '0; e.src = src;
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: per-bit scoreboard plus per-stream ones/length/permutation checks
  int ones = 0;
  int nvalid = 0;
  logic [63:0] seen = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ones = 0; nvalid = 0; seen = '0;
    end else begin
      if (valid && done) check("valid_and_done", 1, 0);
      if (valid) begin
        if (q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          e = q.pop_front();
          check("bit_slot_kind", int'(e.is_done), 0);
          check("bitOut", int'(bitOut), int'(e.bitv));
          check("randNum", int'(randNum), int'(e.rn));
          ones += int'(bitOut);
          nvalid++;
          seen[rev6(randNum)] = 1'b1;
        end
      end
      if (done) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          check("done_slot_kind", int'(e.is_done), 1);
          check("ones_count", ones, int'(e.src));
          check("valid_count", nvalid, 64);
          check("rngb_permutation", int'(&seen), 1);
        end
        ones = 0; nvalid = 0; seen = '0;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_bitOut"}, int'(bitOut), 0);
    check({tag, "_randNum"}, int'(randNum), 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // One stream; srcVal is scrambled after acceptance, busy cycles are counted
  task automatic run_stream(input logic [5:0] src, input int exp_busy, input bit use_hold);
    int bc, vc, hl;
    bit got;
    bc = 0; vc = 0; hl = 0; got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    srcVal = src;
    push_stream(src);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = 1'b0;
      srcVal = 6'($urandom);
      if (busy) bc++;
      if (valid) vc++;
`ifdef UGEN_HOLD_EN
      if (use_hold && valid && (vc == 10 || vc == 40)) begin
        hold = 1'b1; hl = 5;
      end else if (hl > 0) begin
        hl--;
        if (hl == 0) hold = 1'b0;
      end
`else
      if (use_hold) hl++;
`endif
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", int'(got), 1);
    check("busy_cycles", bc, exp_busy);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(valid), 0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, nxt;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_stream(6'd0, 64, 1'b0);
    run_stream(6'd63, 64, 1'b0);
    run_stream(6'd32, 64, 1'b0);

    // Mid-stream reset at valid cycle 20, then identical restart
    @(negedge clk);
    start = 1'b1; srcVal = 6'd45; push_stream(6'd45);
    vc = 0;
    for (int i = 0; i < 100 && vc < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) vc++;
    end
    check("abort_reached_bit20", vc, 20);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_done_queue", q.size(), 0);
    run_stream(6'd45, 64, 1'b0);

    // start held high, srcVal changing every cycle: accepts every 66 cycles
    nxt = 0;
    for (int cyc = 0; cyc <= 132; cyc++) begin
      @(negedge clk);
      start = 1'b1;
      srcVal = 6'((cyc * 13 + 5) & 63);
      if (cyc == nxt) begin
        push_stream(srcVal);
        nxt += 66;
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();

`ifdef UGEN_HOLD_EN
    run_stream(6'd37, 74, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
